// File: rtl/tempsens_sar_ctrl_if.sv
// Control/result and delay-cell signals of the SAR temperature-sensor sequencer.
//   i_start, i_continuous, i_abort : conversion control from tick/display logic
//   i_tempdelay                    : asynchronous delay-cell output
//   o_dac_data, o_dac_en,
//   o_precharge_n                  : drive to the analog delay cell
//   o_busy, o_done, o_result,
//   o_overflow, o_underflow        : status and committed result
// master = surrounding logic / cell, slave = the sequencer.
interface tempsens_sar_ctrl_if #(
    parameter int unsigned N_VDAC = 7
);
    logic              i_start;
    logic              i_continuous;
    logic              i_abort;
    logic              i_tempdelay;
    logic [N_VDAC-1:0] o_dac_data;
    logic              o_dac_en;
    logic              o_precharge_n;
    logic              o_busy;
    logic              o_done;
    logic [N_VDAC-1:0] o_result;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_start, i_continuous, i_abort, i_tempdelay,
        input  o_dac_data, o_dac_en, o_precharge_n, o_busy, o_done,
               o_result, o_overflow, o_underflow
    );

    modport slave (
        input  i_start, i_continuous, i_abort, i_tempdelay,
        output o_dac_data, o_dac_en, o_precharge_n, o_busy, o_done,
               o_result, o_overflow, o_underflow
    );
endinterface

// File: rtl/tempsens_sar_ctrl.sv
// Successive-approximation sequencer for the temperature-dependent delay cell.
// Runs an N_VDAC-step binary search; each trial goes through precharge,
// discharge, measure and decide, then the synchronized cell output keeps or
// clears the trial bit.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : tempsens_sar_ctrl_if.slave (control, cell drive, result)
module tempsens_sar_ctrl #(
    parameter int unsigned N_VDAC      = 7,
    parameter int unsigned MEAS_CYCLES = 4,
    parameter int unsigned IDLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    tempsens_sar_ctrl_if.slave bus
);

    localparam int unsigned BIT_W  = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
    localparam int unsigned MEAS_W = $clog2(MEAS_CYCLES);
    localparam int unsigned WAIT_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [N_VDAC-1:0] ALL_ONES   = '1;
    localparam logic [N_VDAC-1:0] TRIAL_INIT = N_VDAC'(1) << (N_VDAC - 1);
    localparam logic [BIT_W-1:0]  TOP_BIT    = BIT_W'(N_VDAC - 1);
    localparam logic [MEAS_W-1:0] MEAS_LAST  = MEAS_W'(MEAS_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(IDLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_DISCHARGE,
        S_MEASURE,
        S_DECIDE,
        S_WAIT
    } state_t;

    state_t             state_q,     state_nxt;
    logic [N_VDAC-1:0]  trial_q,     trial_nxt;
    logic [BIT_W-1:0]   bit_q,       bit_nxt;
    logic [MEAS_W-1:0]  meas_q,      meas_nxt;
    logic [WAIT_W-1:0]  wait_q,      wait_nxt;
    logic               hit_q,       hit_nxt;
    logic               miss_q,      miss_nxt;
    logic [N_VDAC-1:0]  result_q,    result_nxt;
    logic               ovf_q,       ovf_nxt;
    logic               unf_q,       unf_nxt;
    logic               done_q,      done_nxt;
    logic               busy_q,      busy_nxt;
    logic               dac_en_q,    dac_en_nxt;
    logic [N_VDAC-1:0]  dac_data_q,  dac_data_nxt;
    logic               pc_n_q,      pc_n_nxt;
    logic               start_conv;
    logic [1:0]         sync_q;

    // Two-flop synchronizer for the asynchronous cell output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.i_tempdelay};
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            trial_q    <= '0;
            bit_q      <= '0;
            meas_q     <= '0;
            wait_q     <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            dac_en_q   <= 1'b0;
            dac_data_q <= ALL_ONES;
            pc_n_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            trial_q    <= trial_nxt;
            bit_q      <= bit_nxt;
            meas_q     <= meas_nxt;
            wait_q     <= wait_nxt;
            hit_q      <= hit_nxt;
            miss_q     <= miss_nxt;
            result_q   <= result_nxt;
            ovf_q      <= ovf_nxt;
            unf_q      <= unf_nxt;
            done_q     <= done_nxt;
            busy_q     <= busy_nxt;
            dac_en_q   <= dac_en_nxt;
            dac_data_q <= dac_data_nxt;
            pc_n_q     <= pc_n_nxt;
        end
    end

    // Next-state, search update and next-output decode.
    always_comb begin
        state_nxt    = state_q;
        trial_nxt    = trial_q;
        bit_nxt      = bit_q;
        meas_nxt     = meas_q;
        wait_nxt     = wait_q;
        hit_nxt      = hit_q;
        miss_nxt     = miss_q;
        result_nxt   = result_q;
        ovf_nxt      = ovf_q;
        unf_nxt      = unf_q;
        done_nxt     = 1'b0;
        start_conv   = 1'b0;
        busy_nxt     = 1'b0;
        dac_en_nxt   = 1'b0;
        dac_data_nxt = ALL_ONES;
        pc_n_nxt     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    start_conv = 1'b1;
                end
            end
            S_PRECHARGE: begin
                state_nxt = S_DISCHARGE;
            end
            S_DISCHARGE: begin
                state_nxt = S_MEASURE;
                meas_nxt  = '0;
            end
            S_MEASURE: begin
                if (meas_q == MEAS_LAST) begin
                    state_nxt = S_DECIDE;
                end else begin
                    meas_nxt = meas_q + MEAS_W'(1);
                end
            end
            S_DECIDE: begin
                // A 1 from the cell means the threshold is at or above this code.
                trial_nxt[bit_q] = sync_q[1];
                hit_nxt          = hit_q | sync_q[1];
                miss_nxt         = miss_q | ~sync_q[1];
                if (bit_q != '0) begin
                    trial_nxt[bit_q - BIT_W'(1)] = 1'b1;
                    bit_nxt   = bit_q - BIT_W'(1);
                    state_nxt = S_PRECHARGE;
                end else begin
                    result_nxt = trial_nxt;
                    ovf_nxt    = ~miss_nxt;
                    unf_nxt    = ~hit_nxt;
                    done_nxt   = 1'b1;
                    wait_nxt   = '0;
                    state_nxt  = bus.i_continuous ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                // After IDLE_CYCLES counted cycles, this cycle acts as a started IDLE.
                if (!bus.i_continuous) begin
                    state_nxt = S_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    start_conv = 1'b1;
                end else begin
                    wait_nxt = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (start_conv) begin
            state_nxt = S_PRECHARGE;
            trial_nxt = TRIAL_INIT;
            bit_nxt   = TOP_BIT;
            hit_nxt   = 1'b0;
            miss_nxt  = 1'b0;
            wait_nxt  = '0;
        end

        // Abort wins over start and over commit; the committed result is untouched.
        if (bus.i_abort) begin
            state_nxt  = S_IDLE;
            wait_nxt   = '0;
            result_nxt = result_q;
            ovf_nxt    = ovf_q;
            unf_nxt    = unf_q;
            done_nxt   = 1'b0;
        end

        // Cell drive follows the state being entered so it lines up with that state.
        case (state_nxt)
            S_PRECHARGE: begin
                busy_nxt   = 1'b1;
                dac_en_nxt = 1'b1;
            end
            S_DISCHARGE: begin
                busy_nxt     = 1'b1;
                dac_en_nxt   = 1'b1;
                dac_data_nxt = '0;
                pc_n_nxt     = 1'b1;
            end
            S_MEASURE, S_DECIDE: begin
                busy_nxt     = 1'b1;
                dac_en_nxt   = 1'b1;
                dac_data_nxt = trial_nxt;
                pc_n_nxt     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.o_dac_data    = dac_data_q;
    assign bus.o_dac_en      = dac_en_q;
    assign bus.o_precharge_n = pc_n_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_result      = result_q;
    assign bus.o_overflow    = ovf_q;
    assign bus.o_underflow   = unf_q;

endmodule
